// File: rtl/uart_rx_pkg.sv
// Shared UART RX constants plus the oversampling legality rule.
// The edge counter's config check uses the same rule.
package uart_rx_pkg;

   localparam logic UART_IDLE_LVL   = 1'b1;
   localparam int   FIRST_DATA_BIT  = 1;
   localparam int   MAX_NUM_SAMPLES = 7;

   // The vote window must be centred and must close before decision edge ps-2.
   function automatic logic vote_legal(input int unsigned ps, input int unsigned n);
      int unsigned h;
      int unsigned mid;
      if (n == 0 || (n % 2) == 0 || n > MAX_NUM_SAMPLES) return 1'b0;
      if ((ps % 2) != 0 || ps < 4) return 1'b0;
      h   = (n - 1) / 2;
      mid = ps >> 1;
      if (mid < h) return 1'b0;
      if (mid + h > ps - 3) return 1'b0;
      return 1'b1;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Optional synchroniser for the serial line.
// It is a shift chain reset to the idle level, or a wire when STAGES is 0.
module uart_rx_sync
   import uart_rx_pkg::*;
#(
   parameter int STAGES = 0
) (
   input  logic CLK,
   input  logic RST,
   input  logic din,
   output logic dout
);

   generate
      if (STAGES == 0) begin : g_pass
         logic unused_clk_rst;
         assign unused_clk_rst = CLK & RST;
         assign dout = din;
      end else begin : g_chain
         logic [STAGES-1:0] chain;
         always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
               chain <= {STAGES{UART_IDLE_LVL}};
            end else begin
               chain <= (chain << 1) | STAGES'(din);
            end
         end
         assign dout = chain[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/uart_rx_vote_sampler.sv
// Majority-vote bit sampler for the UART RX path. It samples NUM_SAMPLES points
// around the bit centre and emits the voted bit with a valid strobe and a noise flag.
module uart_rx_vote_sampler
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_W  = 6,
   parameter int NUM_SAMPLES = 3,
   parameter int BIT_CNT_W   = 4,
   parameter int SYNC_STAGES = 0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  data_samp_en,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  S_RX_IN,
   input  logic [PRESCALE_W-1:0] edge_cnt,
   input  logic [BIT_CNT_W-1:0]  bit_cnt,
   output logic                  sampled_bit,
   output logic                  sample_valid,
   output logic                  noise_flag,
   output logic                  sample_out_flag,
   output logic                  cfg_err
);

   localparam int H     = (NUM_SAMPLES - 1) / 2;
   localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

   localparam logic [CNT_W-1:0]      N_FULL    = CNT_W'(NUM_SAMPLES);
   localparam logic [CNT_W-1:0]      H_CNT     = CNT_W'(H);
   localparam logic [PRESCALE_W-1:0] H_PS      = PRESCALE_W'(H);
   localparam logic [BIT_CNT_W-1:0]  FIRST_BIT = BIT_CNT_W'(FIRST_DATA_BIT);

   logic                  rx_line;
   logic                  en_q;
   logic [PRESCALE_W-1:0] ps_q;
   logic [CNT_W-1:0]      ones_cnt;
   logic [CNT_W-1:0]      n_cnt;

   logic                  latch;
   logic                  legal_eff;
   logic [PRESCALE_W-1:0] ps_eff;
   logic [PRESCALE_W-1:0] mid;
   logic [PRESCALE_W-1:0] win_first;
   logic [PRESCALE_W-1:0] win_last;
   logic [PRESCALE_W-1:0] dec_edge;
   logic                  win_start;
   logic                  in_window;
   logic                  dec_hit;

   uart_rx_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .CLK  (CLK),
      .RST  (RST),
      .din  (S_RX_IN),
      .dout (rx_line)
   );

   // On the enable rising edge the incoming prescale applies immediately,
   // so a bit whose window opens in the latch cycle is still sampled.
   always_comb begin
      latch     = data_samp_en & ~en_q;
      ps_eff    = latch ? prescale : ps_q;
      legal_eff = vote_legal(32'(ps_eff), 32'(NUM_SAMPLES));
      mid       = ps_eff >> 1;
      win_first = mid - H_PS;
      win_last  = mid + H_PS;
      dec_edge  = ps_eff - PRESCALE_W'(2);
      win_start = (edge_cnt == win_first);
      in_window = (edge_cnt >= win_first) && (edge_cnt <= win_last);
      dec_hit   = (edge_cnt == dec_edge);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         en_q            <= 1'b0;
         ps_q            <= '0;
         ones_cnt        <= '0;
         n_cnt           <= '0;
         sampled_bit     <= UART_IDLE_LVL;
         sample_valid    <= 1'b0;
         noise_flag      <= 1'b0;
         sample_out_flag <= 1'b0;
         cfg_err         <= 1'b0;
      end else begin
         en_q         <= data_samp_en;
         sample_valid <= 1'b0;

         if (latch) begin
            ps_q    <= prescale;
            cfg_err <= ~legal_eff;
         end

         if (!data_samp_en) begin
            ones_cnt        <= '0;
            n_cnt           <= '0;
            sample_out_flag <= 1'b0;
         end else if (legal_eff) begin
            if (dec_hit) begin
               // An interrupted window leaves n_cnt short, and that bit is dropped.
               if (n_cnt == N_FULL) begin
                  sampled_bit  <= (ones_cnt > H_CNT);
                  noise_flag   <= (ones_cnt != '0) && (ones_cnt != N_FULL);
                  sample_valid <= 1'b1;
                  if (bit_cnt == FIRST_BIT) begin
                     sample_out_flag <= 1'b1;
                  end
               end
               n_cnt <= '0;
            end else if (win_start) begin
               ones_cnt <= CNT_W'(rx_line);
               n_cnt    <= CNT_W'(1);
            end else if (in_window) begin
               ones_cnt <= ones_cnt + CNT_W'(rx_line);
               n_cnt    <= n_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule
